// File: rtl/ariane_soc_pkg.sv
// SoC address-map constants used by the DH control block.
package ariane_soc;

    localparam logic [63:0] DHBase   = 64'h0000_0000_5000_0000;
    localparam logic [63:0] DHLength = 64'h0000_0000_0001_0000;

endpackage

// File: rtl/dh_pkg.sv
// Shared register offsets, bit indices and FSM encoding for the DH control block.
package dh_pkg;

    localparam logic [15:0] OFF_CTRL   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_BASE   = 16'h0010;
    localparam logic [15:0] OFF_EXP    = 16'h0018;
    localparam logic [15:0] OFF_MOD    = 16'h0020;
    localparam logic [15:0] OFF_RESULT = 16'h0028;

    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;
    localparam int unsigned STATUS_ERR_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/dh_ctrl_regs.sv
// Memory-mapped control/status registers and launch FSM for an external
// modular-exponentiation engine.
module dh_ctrl_regs
    import dh_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter logic [63:0] BaseAddr  = ariane_soc::DHBase
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [63:0]            addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   eng_start_o,
    output logic [DataWidth-1:0]   eng_base_o,
    output logic [DataWidth-1:0]   eng_exp_o,
    output logic [DataWidth-1:0]   eng_mod_o,
    input  logic                   eng_done_i,
    input  logic [DataWidth-1:0]   eng_result_i,
    output logic                   irq_o
);

    localparam int unsigned NumBytes = DataWidth / 8;

    function automatic logic [DataWidth-1:0] merge_be(
        input logic [DataWidth-1:0] old_val,
        input logic [DataWidth-1:0] new_val,
        input logic [NumBytes-1:0]  be
    );
        logic [DataWidth-1:0] res;
        res = old_val;
        for (int i = 0; i < NumBytes; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    state_e               state_q, state_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic                 err_flag_q, err_flag_d;
    logic [DataWidth-1:0] base_q, base_d;
    logic [DataWidth-1:0] exp_q, exp_d;
    logic [DataWidth-1:0] mod_q, mod_d;
    logic [DataWidth-1:0] result_q, result_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    logic [15:0] offset;
    logic        hit_ctrl, hit_status, hit_base, hit_exp, hit_mod, hit_result, mapped;
    logic        busy, start_wr, mod_zero_start, acc_err, launch;
    logic        done_set, done_clr, err_set, err_clr;
    logic [DataWidth-1:0] rd_mux;

    assign offset = addr_i[15:0];
    assign busy   = (state_q != ST_IDLE);

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        hit_ctrl   = 1'b0;
        hit_status = 1'b0;
        hit_base   = 1'b0;
        hit_exp    = 1'b0;
        hit_mod    = 1'b0;
        hit_result = 1'b0;
        if (addr_i[63:16] == BaseAddr[63:16]) begin
            unique case (offset)
                OFF_CTRL:   hit_ctrl   = 1'b1;
                OFF_STATUS: hit_status = 1'b1;
                OFF_BASE:   hit_base   = 1'b1;
                OFF_EXP:    hit_exp    = 1'b1;
                OFF_MOD:    hit_mod    = 1'b1;
                OFF_RESULT: hit_result = 1'b1;
                default:    ;
            endcase
        end
    end

    assign mapped = hit_ctrl | hit_status | hit_base | hit_exp | hit_mod | hit_result;

    // A START request is a CTRL write with byte 0 enabled and bit 0 set.
    assign start_wr       = we_i & hit_ctrl & be_i[0] & wdata_i[CTRL_START_BIT];
    assign mod_zero_start = start_wr & ~busy & (mod_q == '0);
    assign acc_err = ~mapped
                   | (we_i & hit_result)
                   | (we_i & busy & (hit_base | hit_exp | hit_mod))
                   | (start_wr & busy)
                   | mod_zero_start;
    assign launch  = req_i & ~acc_err & start_wr;

    always_comb begin
        rd_mux = '0;
        if (hit_ctrl)   rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
        if (hit_status) begin
            rd_mux[STATUS_BUSY_BIT] = busy;
            rd_mux[STATUS_DONE_BIT] = done_q;
            rd_mux[STATUS_ERR_BIT]  = err_flag_q;
        end
        if (hit_base)   rd_mux = base_q;
        if (hit_exp)    rd_mux = exp_q;
        if (hit_mod)    rd_mux = mod_q;
        if (hit_result) rd_mux = result_q;
    end

    always_comb begin
        state_d   = state_q;
        irq_en_d  = irq_en_q;
        base_d    = base_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        result_d  = result_q;
        rvalid_d  = req_i;
        rsp_err_d = 1'b0;
        rdata_d   = '0;
        done_set  = 1'b0;
        done_clr  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;

        if (req_i) begin
            if (acc_err) begin
                rsp_err_d = 1'b1;
                err_set   = mod_zero_start;
            end else if (we_i) begin
                if (hit_ctrl && be_i[0]) irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
                if (hit_status && be_i[0]) begin
                    done_clr = wdata_i[STATUS_DONE_BIT];
                    err_clr  = wdata_i[STATUS_ERR_BIT];
                end
                if (hit_base) base_d = merge_be(base_q, wdata_i, be_i);
                if (hit_exp)  exp_d  = merge_be(exp_q,  wdata_i, be_i);
                if (hit_mod)  mod_d  = merge_be(mod_q,  wdata_i, be_i);
            end else begin
                rdata_d = rd_mux;
            end
        end

        unique case (state_q)
            ST_IDLE:  if (launch) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (eng_done_i) begin
                    result_d = eng_result_i;
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        // Hardware set takes priority over a software clear in the same cycle.
        done_d     = done_set | (done_q & ~done_clr);
        err_flag_d = err_set  | (err_flag_q & ~err_clr);
        irq_d      = irq_en_q & done_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_flag_q <= 1'b0;
            base_q     <= '0;
            exp_q      <= '0;
            mod_q      <= '0;
            result_q   <= '0;
            rvalid_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            err_flag_q <= err_flag_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            mod_q      <= mod_d;
            result_q   <= result_d;
            rvalid_q   <= rvalid_d;
            rsp_err_q  <= rsp_err_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = rsp_err_q;
    assign eng_start_o = (state_q == ST_START);
    assign eng_base_o  = base_q;
    assign eng_exp_o   = exp_q;
    assign eng_mod_o   = mod_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_dh_ctrl_regs.sv
// Directed, table-driven bench for dh_ctrl_regs plus multi-cycle corner sequences.
module tb_dh_ctrl_regs;

    localparam logic [63:0] WIN = 64'h0000_0000_5000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o, eng_start_o, irq_o;
    logic [63:0] rdata_o, eng_base_o, eng_exp_o, eng_mod_o;
    logic        eng_done_i = 1'b0;
    logic [63:0] eng_result_i = '0;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    dh_ctrl_regs #(.DataWidth(64), .BaseAddr(WIN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .eng_start_o(eng_start_o),
        .eng_base_o(eng_base_o), .eng_exp_o(eng_exp_o), .eng_mod_o(eng_mod_o),
        .eng_done_i(eng_done_i), .eng_result_i(eng_result_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (eng_start_o) start_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [63:0] rd;
    logic        er, rv;

    task automatic bus(input logic we, input logic [15:0] off, input logic [63:0] wd,
                       input logic [7:0] be, input logic do_done, input logic [63:0] res);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = WIN | {48'h0, off}; wdata_i = wd; be_i = be;
        eng_done_i = do_done; eng_result_i = res;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0; eng_done_i = 1'b0;
        rd = rdata_o; er = err_o; rv = rvalid_o;
    endtask

    task automatic wr(input string name, input logic [15:0] off, input logic [63:0] wd, input logic exp_err);
        bus(1'b1, off, wd, 8'hFF, 1'b0, '0);
        check({name, " err"}, {63'h0, er}, {63'h0, exp_err});
    endtask

    task automatic rd_chk(input string name, input logic [15:0] off, input logic [63:0] exp);
        bus(1'b0, off, '0, 8'hFF, 1'b0, '0);
        check({name, " err"}, {63'h0, er}, 64'h0);
        check(name, rd, exp);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];
    int   s0;

    initial begin
        vecs[0]  = '{"rst ctrl",      1'b0, WIN | 64'h00, 64'h0, 8'hFF, 1'b0, 64'h0};
        vecs[1]  = '{"rst status",    1'b0, WIN | 64'h08, 64'h0, 8'hFF, 1'b0, 64'h0};
        vecs[2]  = '{"rst result",    1'b0, WIN | 64'h28, 64'h0, 8'hFF, 1'b0, 64'h0};
        vecs[3]  = '{"wr base",       1'b1, WIN | 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 64'h0};
        vecs[4]  = '{"rd base",       1'b0, WIN | 64'h10, 64'h0, 8'hFF, 1'b0, 64'h1122_3344_5566_7788};
        vecs[5]  = '{"wr base be",    1'b1, WIN | 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0, 64'h0};
        vecs[6]  = '{"rd base be",    1'b0, WIN | 64'h10, 64'h0, 8'hFF, 1'b0, 64'h1122_3344_AAAA_AAAA};
        vecs[7]  = '{"wr result",     1'b1, WIN | 64'h28, 64'h1, 8'hFF, 1'b1, 64'h0};
        vecs[8]  = '{"rd outside",    1'b0, 64'h7000_0008, 64'h0, 8'hFF, 1'b1, 64'h0};
        vecs[9]  = '{"rd unmapped",   1'b0, WIN | 64'h30, 64'h0, 8'hFF, 1'b1, 64'h0};
        vecs[10] = '{"rd unaligned",  1'b0, WIN | 64'h0C, 64'h0, 8'hFF, 1'b1, 64'h0};
        vecs[11] = '{"wr exp unal",   1'b1, WIN | 64'h1C, 64'hFFFF, 8'hFF, 1'b1, 64'h0};
        vecs[12] = '{"rd exp",        1'b0, WIN | 64'h18, 64'h0, 8'hFF, 1'b0, 64'h0};
        vecs[13] = '{"wr ctrl irqen", 1'b1, WIN | 64'h00, 64'h2, 8'h01, 1'b0, 64'h0};
        vecs[14] = '{"rd ctrl",       1'b0, WIN | 64'h00, 64'h0, 8'hFF, 1'b0, 64'h2};

        #2;
        check("rst rvalid", {63'h0, rvalid_o}, 64'h0);
        check("rst irq", {63'h0, irq_o}, 64'h0);
        check("rst start", {63'h0, eng_start_o}, 64'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            req_i = 1'b1; we_i = vecs[i].we; addr_i = vecs[i].addr;
            wdata_i = vecs[i].wdata; be_i = vecs[i].be;
            #1;
            if (i == 0) check("gnt", {63'h0, gnt_o}, 64'h1);
            @(negedge clk_i);
            req_i = 1'b0; we_i = 1'b0;
            check({vecs[i].name, " rvalid"}, {63'h0, rvalid_o}, 64'h1);
            check({vecs[i].name, " err"}, {63'h0, err_o}, {63'h0, vecs[i].exp_err});
            check({vecs[i].name, " rdata"}, rdata_o, vecs[i].exp_rdata);
        end
        @(negedge clk_i);
        check("rvalid idle", {63'h0, rvalid_o}, 64'h0);

        // Nominal launch and completion.
        wr("base5", 16'h10, 64'd5, 1'b0);
        wr("exp3", 16'h18, 64'd3, 1'b0);
        wr("mod23", 16'h20, 64'd23, 1'b0);
        s0 = start_cnt;
        wr("ctrl start", 16'h00, 64'h3, 1'b0);
        repeat (3) @(negedge clk_i);
        check("one start pulse", start_cnt, s0 + 1);
        check("eng_base", eng_base_o, 64'd5);
        check("eng_exp", eng_exp_o, 64'd3);
        check("eng_mod", eng_mod_o, 64'd23);
        rd_chk("status busy", 16'h08, 64'h1);
        wr("exp7 busy", 16'h18, 64'd7, 1'b1);
        rd_chk("exp kept", 16'h18, 64'd3);
        s0 = start_cnt;
        wr("start busy", 16'h00, 64'h3, 1'b1);
        repeat (2) @(negedge clk_i);
        check("no restart", start_cnt, s0);
        @(negedge clk_i);
        eng_result_i = 64'd10; eng_done_i = 1'b1;
        @(negedge clk_i);
        eng_done_i = 1'b0;
        rd_chk("result10", 16'h28, 64'd10);
        rd_chk("status done", 16'h08, 64'h2);
        check("irq set", {63'h0, irq_o}, 64'h1);

        // Clear DONE, relaunch, then clear DONE in the same cycle the engine finishes.
        wr("clr done", 16'h08, 64'h2, 1'b0);
        @(negedge clk_i);
        check("irq clr", {63'h0, irq_o}, 64'h0);
        wr("start2", 16'h00, 64'h3, 1'b0);
        bus(1'b1, 16'h08, 64'h2, 8'hFF, 1'b1, 64'd17);
        check("w1c+done err", {63'h0, er}, 64'h0);
        rd_chk("done wins", 16'h08, 64'h2);
        rd_chk("result17", 16'h28, 64'd17);

        // START with MOD==0.
        wr("clr all", 16'h08, 64'h6, 1'b0);
        wr("mod0", 16'h20, 64'd0, 1'b0);
        s0 = start_cnt;
        wr("start mod0", 16'h00, 64'h1, 1'b1);
        repeat (2) @(negedge clk_i);
        check("mod0 no start", start_cnt, s0);
        rd_chk("status err", 16'h08, 64'h4);
        wr("clr err", 16'h08, 64'h4, 1'b0);
        rd_chk("status clear", 16'h08, 64'h0);

        // Reset mid-BUSY, then a late completion.
        wr("mod9", 16'h20, 64'd9, 1'b0);
        wr("start3", 16'h00, 64'h3, 1'b0);
        rd_chk("busy3", 16'h08, 64'h1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("rst irq mid", {63'h0, irq_o}, 64'h0);
        check("rst start mid", {63'h0, eng_start_o}, 64'h0);
        #2 rst_i = 1'b0;
        s0 = start_cnt;
        @(negedge clk_i);
        eng_result_i = 64'd99; eng_done_i = 1'b1;
        @(negedge clk_i);
        eng_done_i = 1'b0;
        rd_chk("late result", 16'h28, 64'd0);
        rd_chk("late status", 16'h08, 64'h0);
        rd_chk("mod cleared", 16'h20, 64'd0);
        @(negedge clk_i);
        check("late irq", {63'h0, irq_o}, 64'h0);
        check("late no start", start_cnt, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
